// File: rtl/fp_align_shifter.sv
// fp_align_shifter: pipelined logarithmic barrel shifter for mantissa alignment
// (logical right, with guard/round/sticky) and normalisation (logical left).
// A valid/ready handshake with a global stall sits in front of the pipeline.
module fp_align_shifter #(
    parameter int unsigned W    = 11,
    parameter int unsigned SW   = 4,
    parameter int unsigned PIPE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [SW-1:0] in_amt,
    input  logic          in_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [2:0]    out_grs
);

    // Data plus guard and round positions below the LSB.
    localparam int unsigned EW = W + 2;

    logic advance;

    // Whole pipeline moves together; stall only when the output is held.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < SW; k++) begin : g_lvl
        localparam int unsigned S    = 1 << k;
        // Amount bits still to be applied at this level (bit 0 is this level's).
        localparam int unsigned AW   = SW - k;
        localparam bit          LAST = (k == SW - 1);
        localparam bit          REG  = (PIPE != 0) || LAST;

        logic [EW-1:0] src_ext;
        logic          src_sticky;
        logic [AW-1:0] src_amt;
        logic          src_dir;
        logic          src_valid;

        logic          dropped;
        logic [EW-1:0] ext_d;
        logic          sticky_d;

        logic [EW-1:0] ext_out;
        logic          sticky_out;
        logic          valid_out;

        if (k == 0) begin : g_src
            assign src_ext    = {in_data, 2'b00};
            assign src_sticky = 1'b0;
            assign src_amt    = in_amt;
            assign src_dir    = in_dir;
            assign src_valid  = in_valid;
        end else begin : g_src
            assign src_ext    = g_lvl[k-1].ext_out;
            assign src_sticky = g_lvl[k-1].sticky_out;
            assign src_amt    = g_lvl[k-1].g_fwd.amt_out;
            assign src_dir    = g_lvl[k-1].g_fwd.dir_out;
            assign src_valid  = g_lvl[k-1].valid_out;
        end

        // Bits falling off below the round position on a right step.
        if (S >= EW) begin : g_drop
            assign dropped = |src_ext;
        end else begin : g_drop
            assign dropped = |src_ext[S-1:0];
        end

        // Apply this level's 2^k step when its amount bit is set.
        always_comb begin
            ext_d    = src_ext;
            sticky_d = src_sticky;
            if (src_amt[0]) begin
                if (src_dir) begin
                    ext_d = src_ext << S;
                end else begin
                    ext_d    = src_ext >> S;
                    sticky_d = src_sticky | dropped;
                end
            end
        end

        if (REG) begin : g_stage
            // Stage register: cleared by reset, held while the output stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ext_out    <= '0;
                    sticky_out <= 1'b0;
                    valid_out  <= 1'b0;
                end else if (advance) begin
                    ext_out    <= ext_d;
                    sticky_out <= sticky_d;
                    valid_out  <= src_valid;
                end
            end
        end else begin : g_stage
            assign ext_out    = ext_d;
            assign sticky_out = sticky_d;
            assign valid_out  = src_valid;
        end

        // Remaining amount bits and direction travel with the data.
        if (!LAST) begin : g_fwd
            logic [AW-2:0] amt_out;
            logic          dir_out;

            if (REG) begin : g_reg
                // Control travels in lock-step with the data register.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        amt_out <= '0;
                        dir_out <= 1'b0;
                    end else if (advance) begin
                        amt_out <= src_amt[AW-1:1];
                        dir_out <= src_dir;
                    end
                end
            end else begin : g_wire
                assign amt_out = src_amt[AW-1:1];
                assign dir_out = src_dir;
            end
        end
    end

    assign out_valid = g_lvl[SW-1].valid_out;
    assign out_data  = g_lvl[SW-1].ext_out[EW-1:2];
    assign out_grs   = {g_lvl[SW-1].ext_out[1:0], g_lvl[SW-1].sticky_out};

endmodule
